// File: rtl/ariane_pkg.sv
// Shared types for the commit fence sequencer: the serialising-instruction
// kind reported by commit and the sequencer FSM states.
package ariane_pkg;

    // Encoding of the serialising instruction at the commit head
    typedef enum logic [1:0] {
        FENCE      = 2'd0,
        FENCE_I    = 2'd1,
        SFENCE_VMA = 2'd2,
        FENCE_T    = 2'd3
    } fence_kind_e;

    // Sequencer states, walked in a fixed order: drain, D$, I$, TLB, done
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        FLUSH_DC = 3'd2,
        FLUSH_IC = 3'd3,
        TLB      = 3'd4,
        DONE     = 3'd5
    } fence_seq_state_e;

endpackage

// File: rtl/commit_fence_sequencer.sv
// Commit fence sequencer: accepts one serialising instruction from commit
// port 0, waits for the store buffer to drain, then issues D$ flush, I$ flush
// and TLB flush as needed, and ends with a one-cycle done/pipeline-flush pulse.
// Optional busy-cycle counter enabled by defining CVA6_FENCE_PERF_EN.
module commit_fence_sequencer
    import ariane_pkg::*;
#(
    parameter bit          DcacheWriteBack = 1'b1,
    parameter int unsigned PerfCntWidth    = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic [1:0] req_kind_i,
    output logic       req_ready_o,
    input  logic       abort_i,
    input  logic       no_st_pending_i,
    output logic       flush_dcache_o,
    input  logic       flush_dcache_ack_i,
    output logic       flush_icache_o,
    output logic       flush_tlb_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       flush_pipeline_o
`ifdef CVA6_FENCE_PERF_EN
    ,
    output logic [PerfCntWidth-1:0] perf_busy_cycles_o
`endif
);

    fence_seq_state_e state_q, state_d;
    fence_kind_e      kind_q, kind_d;
    logic [2:0]       needs;

    logic flush_dcache_q;
    logic flush_icache_q;
    logic flush_tlb_q;
    logic busy_q;
    logic done_q;

    // Which resources a kind must flush, packed as {dcache, icache, tlb}
    function automatic logic [2:0] needs_flags(input fence_kind_e kind);
        logic dc, ic, tlb;
        dc  = (kind == FENCE_T) || (DcacheWriteBack && ((kind == FENCE) || (kind == FENCE_I)));
        ic  = (kind == FENCE_I) || (kind == FENCE_T);
        tlb = (kind == SFENCE_VMA) || (kind == FENCE_T);
        return {dc, ic, tlb};
    endfunction

    // First remaining step of the fixed D$ -> I$ -> TLB order, or DONE
    function automatic fence_seq_state_e first_step(input logic [2:0] todo);
        if (todo[2]) begin
            return FLUSH_DC;
        end else if (todo[1]) begin
            return FLUSH_IC;
        end else if (todo[0]) begin
            return TLB;
        end
        return DONE;
    endfunction

    // A request can only be taken while idle and not being flushed away
    assign req_ready_o = (state_q == IDLE) && !abort_i;

    // Next-state decode; abort only cancels while still draining stores
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        needs   = needs_flags(kind_q);
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    kind_d  = fence_kind_e'(req_kind_i);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (no_st_pending_i) begin
                    state_d = first_step(needs);
                end
            end
            FLUSH_DC: begin
                if (flush_dcache_ack_i) begin
                    state_d = first_step(needs & 3'b011);
                end
            end
            FLUSH_IC: state_d = first_step(needs & 3'b001);
            TLB:      state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, latched kind and registered outputs decoded from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            kind_q         <= FENCE;
            flush_dcache_q <= 1'b0;
            flush_icache_q <= 1'b0;
            flush_tlb_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            flush_dcache_q <= (state_d == FLUSH_DC);
            flush_icache_q <= (state_d == FLUSH_IC);
            flush_tlb_q    <= (state_d == TLB);
            busy_q         <= (state_d != IDLE);
            done_q         <= (state_d == DONE);
        end
    end

    assign flush_dcache_o   = flush_dcache_q;
    assign flush_icache_o   = flush_icache_q;
    assign flush_tlb_o      = flush_tlb_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign flush_pipeline_o = done_q;

`ifdef CVA6_FENCE_PERF_EN
    logic [PerfCntWidth-1:0] perf_q, perf_d;

    // Saturating count of cycles in which busy_o is high
    always_comb begin
        perf_d = perf_q;
        if (busy_q && (perf_q != {PerfCntWidth{1'b1}})) begin
            perf_d = perf_q + PerfCntWidth'(1);
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_busy_cycles_o = perf_q;
`else
    // No busy-cycle counter in this build
`endif

endmodule

// File: tb/tb_commit_fence_sequencer.sv
// Bench for commit_fence_sequencer. The main instance uses a write-back D$;
// a second instance without write-back covers the plain FENCE cases.
// Define CVA6_FENCE_PERF_EN to also exercise the busy-cycle counter.
module tb_commit_fence_sequencer;
    import ariane_pkg::*;

`ifdef CVA6_FENCE_PERF_EN
    localparam int unsigned PW = 4;
`else
    localparam int unsigned PW = 32;
`endif

    logic       clk_i;
    logic       rst_ni;
    logic       req_valid_i;
    logic       reqValidNoWb;
    logic [1:0] req_kind_i;
    logic       abort_i;
    logic       no_st_pending_i;
    logic       flush_dcache_ack_i;

    logic req_ready_o, flush_dcache_o, flush_icache_o, flush_tlb_o;
    logic busy_o, done_o, flush_pipeline_o;
    logic readyNoWb, dcNoWb, icNoWb, tlbNoWb, busyNoWb, doneNoWb, pipeNoWb;
`ifdef CVA6_FENCE_PERF_EN
    logic [PW-1:0] perf_busy_cycles_o;
    logic [PW-1:0] perfNoWb;
`endif

    commit_fence_sequencer #(.DcacheWriteBack(1'b1), .PerfCntWidth(PW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_kind_i         (req_kind_i),
        .req_ready_o        (req_ready_o),
        .abort_i            (abort_i),
        .no_st_pending_i    (no_st_pending_i),
        .flush_dcache_o     (flush_dcache_o),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .flush_icache_o     (flush_icache_o),
        .flush_tlb_o        (flush_tlb_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .flush_pipeline_o   (flush_pipeline_o)
`ifdef CVA6_FENCE_PERF_EN
        ,
        .perf_busy_cycles_o (perf_busy_cycles_o)
`endif
    );

    commit_fence_sequencer #(.DcacheWriteBack(1'b0), .PerfCntWidth(PW)) dutNoWb (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (reqValidNoWb),
        .req_kind_i         (req_kind_i),
        .req_ready_o        (readyNoWb),
        .abort_i            (abort_i),
        .no_st_pending_i    (no_st_pending_i),
        .flush_dcache_o     (dcNoWb),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .flush_icache_o     (icNoWb),
        .flush_tlb_o        (tlbNoWb),
        .busy_o             (busyNoWb),
        .done_o             (doneNoWb),
        .flush_pipeline_o   (pipeNoWb)
`ifdef CVA6_FENCE_PERF_EN
        ,
        .perf_busy_cycles_o (perfNoWb)
`endif
    );

    typedef struct {
        logic [7:0] ev;
        int         cyc;
    } expEvent_t;

    expEvent_t expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int doneNoWbCnt = 0;
    int dcNoWbCnt   = 0;
    logic dcPrev = 1'b0;

    // Free-running clock and cycle index
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expectEvent(input logic [7:0] ev, input int at);
        expEvent_t e;
        e.ev  = ev;
        e.cyc = at;
        expQ.push_back(e);
    endtask

    task automatic seeEvent(input logic [7:0] ev);
        expEvent_t e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL event: got %c at cycle %0d, expected none", ev, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.ev != ev || e.cyc != cyc) begin
                mismatched++;
                $display("[TB] FAIL event: got %c at cycle %0d, expected %c at cycle %0d",
                         ev, cyc, e.ev, e.cyc);
            end
        end
    endtask

    // Monitor: D = D$ flush rises, d = D$ flush falls, I/T = I$/TLB pulse, F = done
    always @(negedge clk_i) begin
        if (flush_dcache_o && !dcPrev) seeEvent("D");
        if (!flush_dcache_o && dcPrev) seeEvent("d");
        if (flush_icache_o) seeEvent("I");
        if (flush_tlb_o) seeEvent("T");
        if (done_o) begin
            seeEvent("F");
            checkOutput("flush_pipeline_eq_done", {31'b0, flush_pipeline_o}, 32'd1);
        end
        dcPrev = flush_dcache_o;
        if (doneNoWb) doneNoWbCnt++;
        if (dcNoWb) dcNoWbCnt++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) tick();
    endtask

    task automatic applyStimulus(input logic [1:0] kind, input logic noSt);
        req_valid_i     = 1'b1;
        req_kind_i      = kind;
        no_st_pending_i = noSt;
        #1;
        checkOutput("req_ready_at_accept", {31'b0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int c;
        rst_ni             = 1'b0;
        req_valid_i        = 1'b0;
        reqValidNoWb       = 1'b0;
        req_kind_i         = 2'b00;
        abort_i            = 1'b0;
        no_st_pending_i    = 1'b1;
        flush_dcache_ack_i = 1'b0;
        #2;
        checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'b0, done_o}, 32'd0);
        checkOutput("rst_flush_dcache", {31'b0, flush_dcache_o}, 32'd0);
        checkOutput("rst_flush_icache", {31'b0, flush_icache_o}, 32'd0);
        checkOutput("rst_flush_tlb", {31'b0, flush_tlb_o}, 32'd0);
        checkOutput("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
`ifdef CVA6_FENCE_PERF_EN
        checkOutput("rst_perf", 32'(perf_busy_cycles_o), 32'd0);
`endif
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // FENCE_I with stores pending for 5 cycles, D$ ack 3 cycles after rise
        c = cyc;
        applyStimulus(2'b01, 1'b0);
        expectEvent("D", c + 7);
        expectEvent("d", c + 11);
        expectEvent("I", c + 11);
        expectEvent("F", c + 12);
        waitUntil(c + 1);
        req_valid_i = 1'b0;
        #1;
        checkOutput("fencei_busy_in_drain", {31'b0, busy_o}, 32'd1);
        checkOutput("fencei_not_ready_busy", {31'b0, req_ready_o}, 32'd0);
        waitUntil(c + 6);
        no_st_pending_i = 1'b1;
        waitUntil(c + 10);
        flush_dcache_ack_i = 1'b1;
        waitUntil(c + 11);
        flush_dcache_ack_i = 1'b0;
        waitUntil(c + 12);
        #1;
        checkOutput("not_ready_in_done", {31'b0, req_ready_o}, 32'd0);
        waitUntil(c + 13);
        #1;
        checkOutput("ready_after_done", {31'b0, req_ready_o}, 32'd1);
        checkOutput("idle_after_done", {31'b0, busy_o}, 32'd0);

        // SFENCE_VMA already drained; a store reappearing after DRAIN is ignored
        tick();
        c = cyc;
        applyStimulus(2'b10, 1'b1);
        expectEvent("T", c + 2);
        expectEvent("F", c + 3);
        waitUntil(c + 1);
        req_valid_i = 1'b0;
        waitUntil(c + 2);
        no_st_pending_i = 1'b0;
        waitUntil(c + 4);
        no_st_pending_i = 1'b1;
        #1;
        checkOutput("sfence_idle", {31'b0, busy_o}, 32'd0);

        // FENCE without write-back, aborted while draining
        tick();
        c = cyc;
        reqValidNoWb    = 1'b1;
        req_kind_i      = 2'b00;
        no_st_pending_i = 1'b0;
        waitUntil(c + 1);
        reqValidNoWb = 1'b0;
        abort_i      = 1'b1;
        #1;
        checkOutput("nowb_busy_in_drain", {31'b0, busyNoWb}, 32'd1);
        checkOutput("ready_low_on_abort", {31'b0, req_ready_o}, 32'd0);
        waitUntil(c + 2);
        abort_i         = 1'b0;
        no_st_pending_i = 1'b1;
        #1;
        checkOutput("nowb_idle_after_abort", {31'b0, busyNoWb}, 32'd0);
        checkOutput("nowb_ready_after_abort", {31'b0, readyNoWb}, 32'd1);

        // FENCE without write-back, drained: done two cycles after accept
        tick();
        c = cyc;
        reqValidNoWb = 1'b1;
        req_kind_i   = 2'b00;
        waitUntil(c + 1);
        reqValidNoWb = 1'b0;
        #1;
        checkOutput("nowb_fence_no_done_c1", {31'b0, doneNoWb}, 32'd0);
        waitUntil(c + 2);
        #1;
        checkOutput("nowb_fence_done_c2", {31'b0, doneNoWb}, 32'd1);
        checkOutput("nowb_fence_pipe_c2", {31'b0, pipeNoWb}, 32'd1);
        waitUntil(c + 3);
        #1;
        checkOutput("nowb_fence_done_one_cycle", {31'b0, doneNoWb}, 32'd0);

        // FENCE_T with abort held high from FLUSH_DC onwards
        tick();
        c = cyc;
        applyStimulus(2'b11, 1'b1);
        expectEvent("D", c + 2);
        expectEvent("d", c + 5);
        expectEvent("I", c + 5);
        expectEvent("T", c + 6);
        expectEvent("F", c + 7);
        waitUntil(c + 1);
        req_valid_i = 1'b0;
        waitUntil(c + 2);
        abort_i = 1'b1;
        waitUntil(c + 4);
        flush_dcache_ack_i = 1'b1;
        waitUntil(c + 5);
        flush_dcache_ack_i = 1'b0;
        waitUntil(c + 8);
        abort_i = 1'b0;
        #1;
        checkOutput("fencet_idle", {31'b0, busy_o}, 32'd0);

        // Reset while in FLUSH_DC, then a spurious ack
        tick();
        c = cyc;
        applyStimulus(2'b00, 1'b1);
        expectEvent("D", c + 2);
        expectEvent("d", c + 3);
        waitUntil(c + 1);
        req_valid_i = 1'b0;
        waitUntil(c + 3);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_flush_dcache", {31'b0, flush_dcache_o}, 32'd0);
        checkOutput("async_rst_busy", {31'b0, busy_o}, 32'd0);
        waitUntil(c + 4);
        rst_ni = 1'b1;
        waitUntil(c + 5);
        flush_dcache_ack_i = 1'b1;
        waitUntil(c + 6);
        flush_dcache_ack_i = 1'b0;
        #1;
        checkOutput("spurious_ack_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("spurious_ack_flush_dcache", {31'b0, flush_dcache_o}, 32'd0);

`ifdef CVA6_FENCE_PERF_EN
        // Busy-cycle counter: three cycles, then saturation
        tick();
        c = cyc;
        applyStimulus(2'b10, 1'b1);
        expectEvent("T", c + 2);
        expectEvent("F", c + 3);
        waitUntil(c + 1);
        req_valid_i = 1'b0;
        waitUntil(c + 5);
        #1;
        checkOutput("perf_three_cycles", 32'(perf_busy_cycles_o), 32'd3);
        c = cyc;
        applyStimulus(2'b10, 1'b0);
        expectEvent("T", c + 22);
        expectEvent("F", c + 23);
        waitUntil(c + 1);
        req_valid_i = 1'b0;
        waitUntil(c + 21);
        no_st_pending_i = 1'b1;
        waitUntil(c + 25);
        #1;
        checkOutput("perf_saturated", 32'(perf_busy_cycles_o), 32'hF);
`endif

        tick();
        tick();
        checkOutput("expected_events_left", expQ.size(), 32'd0);
        checkOutput("nowb_done_pulses", doneNoWbCnt, 32'd1);
        checkOutput("nowb_dcache_cycles", dcNoWbCnt, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/commit_fence_sequencer.md
Name: commit_fence_sequencer

Overview:
- Sequences the side effects of serialising instructions retired on commit port 0 (FENCE, FENCE.I, SFENCE.VMA, FENCE.T).
- Takes a single request from the commit stage, waits for the store buffer to drain, and drives D$ flush, I$ flush and TLB flush in a fixed order with per-resource handshakes.
- Finishes with a one-cycle done/pipeline-flush pulse that the controller uses to flush the pipeline.
- Sits between the commit stage and the controller/cache subsystem.

Parameters:
- DcacheWriteBack, 1: 1 = D$ is write-back, so FENCE and FENCE.I also flush the D$; 0 = they skip the D$ flush.
- PerfCntWidth, 32: width of the optional busy-cycle counter.

Ports:
- clk_i  in  1  subsystem clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  1  serialising instruction at commit head
- req_kind_i  in  2  00 FENCE, 01 FENCE_I, 10 SFENCE_VMA, 11 FENCE_T
- req_ready_o  out  1  request accepted this cycle
- abort_i  in  1  pipeline flush from controller (exception/debug)
- no_st_pending_i  in  1  store buffer empty
- flush_dcache_o  out  1  D$ flush request, held as a level
- flush_dcache_ack_i  in  1  D$ flush complete, single-cycle pulse
- flush_icache_o  out  1  I$ flush, single-cycle pulse
- flush_tlb_o  out  1  ITLB/DTLB flush, single-cycle pulse
- busy_o  out  1  state != IDLE
- done_o  out  1  sequence complete, single-cycle pulse; commit acks the instruction
- flush_pipeline_o  out  1  equal to done_o
- perf_busy_cycles_o  out  PerfCntWidth  present only with the optional feature

Behaviour:
- Reset: state IDLE; all outputs 0; latched kind 00; counter 0.
- req_ready_o = (state==IDLE) && !abort_i, combinational. A handshake latches req_kind_i and moves to DRAIN.
- DRAIN:
  - abort_i → IDLE, no outputs asserted.
  - else no_st_pending_i → next step: FLUSH_DC if needs_dc, else FLUSH_IC if needs_ic, else TLB if needs_tlb, else DONE.
  - Minimum 1 cycle in DRAIN even if already drained.
- needs_dc = (kind==FENCE_T) || (DcacheWriteBack && kind inside {FENCE, FENCE_I}).
- needs_ic = kind inside {FENCE_I, FENCE_T}.
- needs_tlb = kind inside {SFENCE_VMA, FENCE_T}.
- FLUSH_DC:
  - flush_dcache_o=1 until the cycle flush_dcache_ack_i=1, inclusive.
  - On ack, flush_dcache_o drops next cycle and the FSM moves to FLUSH_IC, TLB or DONE per the needs_* flags.
  - abort_i is ignored here; a D$ flush is not cancellable.
  - An ack arriving in any other state is ignored.
- FLUSH_IC: flush_icache_o=1 for exactly one cycle, then TLB if needs_tlb, else DONE. abort_i ignored.
- TLB: flush_tlb_o=1 for exactly one cycle, then DONE. abort_i ignored.
- DONE: done_o=flush_pipeline_o=1 for one cycle, then IDLE. A new request is acceptable the following cycle, never in DONE itself.
- Latency with no_st_pending_i=1:
  - FENCE, DcacheWriteBack=0: DRAIN, DONE = done 2 cycles after accept.
  - SFENCE_VMA: DRAIN, TLB, DONE = 3 cycles.
  - FENCE_T: DRAIN, FLUSH_DC(n), FLUSH_IC, TLB, DONE.
- A store that re-appears (no_st_pending_i falls) after DRAIN is exited is ignored.
- A reset mid-sequence returns to IDLE immediately, including dropping flush_dcache_o asynchronously.

Optional Feature:
- Macro: CVA6_FENCE_PERF_EN.
- With it defined:
  - perf_busy_cycles_o exists and increments each cycle busy_o=1.
  - It saturates at all-ones and is cleared only by reset.
- Without it defined: the port and the counter are absent; no other behavioural difference.

Decomposition:
- Shared package ariane_pkg:
  - fence_kind_e, 2-bit enum (FENCE=0, FENCE_I=1, SFENCE_VMA=2, FENCE_T=3).
  - fence_seq_state_e (IDLE, DRAIN, FLUSH_DC, FLUSH_IC, TLB, DONE).
- No sub-module; one FSM plus the optional counter. The needs_* decode is a local function.

Test Plan:
- FENCE_I, DcacheWriteBack=1, no_st_pending_i=0 for 5 cycles, ack 3 cycles after flush_dcache_o rises → flush_dcache_o high 4 cycles, flush_icache_o one pulse next cycle, done_o one cycle later, no flush_tlb_o.
- SFENCE_VMA with store buffer drained at accept → flush_tlb_o at cycle+2, done_o at cycle+3, flush_dcache_o never asserted.
- FENCE with DcacheWriteBack=0 and abort_i asserted in DRAIN → IDLE next cycle, done_o never pulses, req_ready_o=1 again.
- FENCE_T with abort_i held high through FLUSH_DC → sequence completes D$, I$, TLB, done; abort has no effect.
- rst_ni low while in FLUSH_DC → flush_dcache_o=0 at once; busy_o=0; a later spurious flush_dcache_ack_i is ignored.
- With CVA6_FENCE_PERF_EN and PerfCntWidth=4: 20 busy cycles → perf_busy_cycles_o saturates at 4'hF.
